// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative multiply/divide unit with the architectural HI/LO registers of the
// MIPS datapath. MULT/MULTU use radix-2 shift-add and DIV/DIVU use radix-2
// restoring division. Both work on operand magnitudes and fix the sign up in
// the FINISH cycle. MTHI/MTLO, the no-op codes and divide-by-zero all complete
// in a single cycle.
//
// Optional feature macro: MULDIV_FAST_MULT_EN
//   When defined, MULT/MULTU produce the product combinationally at the accept
//   edge and complete like the single-cycle cases. DIV/DIVU are unchanged.
//
// Parameters:
//   WIDTH        operand and HI/LO width (must be >= 4 and even)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset; aborts any operation
//   start        request, accepted only when busy=0
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                110/111 no-op
//   src_a        multiplicand / dividend / MTHI-MTLO data, sampled at accept
//   src_b        multiplier / divisor, sampled at accept
//   busy         iterative operation in progress
//   done         one-cycle pulse; hi/lo hold the result in that cycle
//   div_by_zero  valid with done; DIV/DIVU with src_b=0
//   hi, lo       HI and LO registers
//   state_dbg    current FSM state (IDLE=0, MUL=1, DIV=2, FINISH=3)
//
// Handshake: a request is taken at a rising edge where start=1 and busy=0.
// A start seen while busy=1 is dropped, not queued. Exactly one done pulse
// follows every accepted request, and busy=0 in that done cycle, so a new
// request may be accepted in the same cycle that done is high.

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_DIV    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state_q, state_n;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dbz_q;
  logic [CW-1:0]      cnt_q;
  // Multiply: accumulated product. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  // Multiplicand, shifted left one place per multiply step.
  logic [2*WIDTH-1:0] mcand_q;
  // Multiplier (shifted right per step) or divisor magnitude.
  logic [WIDTH-1:0]   opb_q;
  logic               neg_q;   // product / quotient must be negated
  logic               rneg_q;  // remainder must be negated
  logic               is_div_q;

  // Request decode
  logic             accept;
  logic             op_mul, op_div, op_signed, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign accept    = start & ~busy;
  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = ~op[0];
  assign b_zero    = (src_b == '0);

  // Magnitudes; -2^(WIDTH-1) maps onto itself, which is the correct
  // unsigned magnitude.
  assign mag_a = (op_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign mag_b = (op_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

  // One shift-add multiply step
  logic [2*WIDTH-1:0] mul_sum;
  assign mul_sum = acc_q + (opb_q[0] ? mcand_q : '0);

  // One restoring divide step. The partial remainder is always below the
  // divisor, so after shifting in the next dividend bit it needs WIDTH+1 bits.
  // The trial difference gets one more bit so that its MSB is the borrow.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic             unused_div_bit;

  assign div_shift      = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff       = {1'b0, div_shift} - {2'b00, opb_q};
  assign div_fits       = ~div_diff[WIDTH+1];
  // When the trial fits, the difference is below the divisor, so bit WIDTH is 0.
  assign unused_div_bit = div_diff[WIDTH];
  assign div_rem        = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo        = {acc_q[WIDTH-2:0], div_fits};

  // Sign fix-up applied in the FINISH cycle
  logic [2*WIDTH-1:0] prod_final;
  logic [WIDTH-1:0]   quo_final, rem_final;

  assign prod_final = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quo_final  = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_final  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                             : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  // Extend both operands to 2*WIDTH (sign or zero). The low 2*WIDTH bits of
  // their product are then the exact product for either signedness.
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{WIDTH{op_signed & src_a[WIDTH-1]}}, src_a};
  assign ext_b     = {{WIDTH{op_signed & src_b[WIDTH-1]}}, src_b};
  assign fast_prod = ext_a * ext_b;
`endif

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_div && !b_zero) begin
            state_n = S_DIV;
          end
`ifndef MULDIV_FAST_MULT_EN
          else if (op_mul) begin
            state_n = S_MUL;
          end
`endif
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == CNT_LAST) begin
          state_n = S_FINISH;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q    <= '0;
            is_div_q <= op_div;
            opb_q    <= mag_b;
            neg_q    <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            rneg_q   <= op_signed & src_a[WIDTH-1];
            if (op == OP_MTHI) begin
              hi_q   <= src_a;
              done_q <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo_q   <= src_a;
              done_q <= 1'b1;
            end else if (op_div) begin
              if (b_zero) begin
                // No iteration; HI/LO keep their values.
                done_q <= 1'b1;
                dbz_q  <= 1'b1;
              end else begin
                acc_q <= {{WIDTH{1'b0}}, mag_a};
              end
            end else if (op_mul) begin
`ifdef MULDIV_FAST_MULT_EN
              {hi_q, lo_q} <= fast_prod;
              done_q       <= 1'b1;
`else
              acc_q   <= '0;
              mcand_q <= {{WIDTH{1'b0}}, mag_a};
`endif
            end else begin
              // No-op codes only produce the done pulse.
              done_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q   <= mul_sum;
          mcand_q <= mcand_q << 1;
          opb_q   <= opb_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
        end
        S_DIV: begin
          acc_q <= {div_rem, div_quo};
          cnt_q <= cnt_q + 1'b1;
        end
        S_FINISH: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            hi_q <= rem_final;
            lo_q <= quo_final;
          end else begin
            {hi_q, lo_q} <= prod_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Parametrised iterative multiply/divide unit for the MIPS datapath, with architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO using a start/busy/done handshake; multiplies and divides are radix-2, one bit per cycle.
- Sits beside the combinational ALU in the execute stage; the controller stalls the pipeline while `busy` is high.
- MFHI/MFLO read `hi`/`lo` directly.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- op  input  3  operation, sampled with start: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 accepted as no-op.
- src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data; sampled at accept.
- src_b  input  WIDTH  multiplier / divisor; sampled at accept.
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse; the result is valid on hi/lo in that cycle.
- div_by_zero  output  1  valid with done; set for DIV/DIVU with src_b=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation

- States: IDLE, MUL, DIV, FINISH.

On reset (asynchronous, any state including mid-operation):
- State returns to IDLE; the operation is aborted with no done pulse.
- hi=0, lo=0, busy=0, done=0, div_by_zero=0.

Accept rule:
- A request is accepted at a rising edge where start=1 and busy=0.
- start while busy=1 is ignored; no queueing.

MTHI/MTLO:
- hi (or lo) ← src_a at the accept edge.
- done=1 the following cycle; busy never rises.

No-op codes:
- done pulse only; hi/lo unchanged.

MULT/MULTU:
- For MULT, operands are converted to magnitudes and the result sign is recorded.
- Shift-add over WIDTH cycles into a 2·WIDTH accumulator.
- At the end the product is negated if needed; hi = upper WIDTH bits, lo = lower WIDTH bits.
- Full 2·WIDTH product; overflow is impossible.

DIV/DIVU:
- Restoring division on magnitudes over WIDTH cycles.
- Quotient truncates toward zero; remainder takes the sign of the dividend.
- lo = quotient, hi = remainder.
- Signed −2^(WIDTH−1) / −1 wraps: lo = 0x8000…0, hi = 0. No exception.

Divide by zero (DIV/DIVU with src_b=0):
- No iteration; hi/lo unchanged.
- done=1 and div_by_zero=1 the following cycle.

Outputs and source operands:
- hi/lo never change except at a MTHI/MTLO accept edge or at the edge that raises done.
- src_a/src_b may change freely after accept.

## Timing

- Accept edge = cycle 0.

Iterative MUL/DIV:
- busy=1 during cycles 1..WIDTH; that is WIDTH cycles, plus the FINISH cycle described next.
- FINISH occupies cycle WIDTH+1: busy=1.
- At the FINISH→IDLE edge, hi/lo update and done=1 in cycle WIDTH+2 with busy=0.
- Latency is WIDTH+2 cycles from accept edge to the done cycle.

Back-to-back requests:
- A new start may be accepted in the done cycle itself, since busy=0 there.

Single-cycle cases:
- MTHI/MTLO, no-op codes and divide-by-zero: done in cycle 1, busy stays 0.

Flag and pulse widths:
- div_by_zero is 0 in every cycle where done=0.
- done is exactly one cycle wide.

## Configuration

MULDIV_FAST_MULT_EN:
- Defined: MULT/MULTU compute the product combinationally from the sampled operands and take the same path as the single-cycle cases.
	- hi/lo update at the edge after accept; done is in cycle 1; busy never rises.
	- DIV/DIVU are unaffected.
- Undefined: iterative multiply as specified above.

## Test plan

1. MULT src_a=0xFFFFFFFF, src_b=0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE; done in cycle 34 (cycle 1 with MULDIV_FAST_MULT_EN).
2. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
3. DIV −7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
4. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
5. Preload hi=0x1234 via MTHI, then DIVU 5/0 → done and div_by_zero in cycle 1, hi stays 0x1234, busy never rises.
6. Start DIVU, assert start with other operands at cycle 10 → ignored. Assert reset at cycle 20 → busy=0, hi=lo=0 immediately, no done. After reset release a fresh MTLO 0xA5 → lo=0xA5.
